// File: rtl/sram_port_ctrl.sv
// Request/response front end for port 0 of the single-port OpenRAM-style macro.
// Requests drive the macro directly; read data returns through an in-order response FIFO.
module sram_port_ctrl #(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 32,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  // Both channels use valid/ready: a transfer happens on a rising edge where
  // valid && ready; valid must not depend on ready, ready may depend on valid.
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wmask,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_we,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    sram_csb,
  output logic                    sram_web,
  output logic [DATA_WIDTH/8-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]   sram_addr,
  output logic [DATA_WIDTH-1:0]   sram_din,
  input  logic [DATA_WIDTH-1:0]   sram_dout
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RSP_DEPTH - 1);
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(RSP_DEPTH);

  logic                  req_fire;
  logic                  rsp_fire;
  logic                  push;
  logic                  inflight_v;
  logic                  inflight_we;
  logic [CNT_W-1:0]      count;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W:0]        credit;
  logic                  fifo_we   [RSP_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [RSP_DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Macro port follows the request channel so the macro samples the accepted request itself.
  assign sram_csb   = !req_fire;
  assign sram_web   = !req_we;
  assign sram_wmask = req_we ? req_wmask : '0;
  assign sram_addr  = req_addr;
  assign sram_din   = req_wdata;

  assign rsp_valid = (count != '0);
  assign rsp_fire  = rsp_valid && rsp_ready;
  assign push      = inflight_v;
  assign rsp_we    = fifo_we[rd_ptr];
  assign rsp_rdata = fifo_data[rd_ptr];

  // Slots already owed (stored plus in flight, less the one leaving now) must leave room.
  assign credit    = {1'b0, count} + {{CNT_W{1'b0}}, inflight_v} - {{CNT_W{1'b0}}, rsp_fire};
  assign req_ready = reset_n && (credit < DEPTH_C);
  assign req_fire  = req_valid && req_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight_v  <= 1'b0;
      inflight_we <= 1'b0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      inflight_v  <= req_fire;
      inflight_we <= req_we;
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (rsp_fire) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, rsp_fire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // The macro drives dout after the falling edge, so it is stable at the edge that pushes.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_we[wr_ptr]   <= inflight_we;
      fifo_data[wr_ptr] <= inflight_we ? '0 : sram_dout;
    end
  end

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Directed and random bench for sram_port_ctrl with a behavioural macro model
// and an expected-response queue checked on every response handshake.
module tb_sram_port_ctrl;

  localparam int AW = 27;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic [3:0]    req_wmask;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_we;
  logic [31:0]   rsp_rdata;
  logic          sram_csb;
  logic          sram_web;
  logic [3:0]    sram_wmask;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_din;
  logic [31:0]   sram_dout = 32'h0;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int n_acc      = 0;
  int n_pop      = 0;
  logic [31:0] last_rdata = 32'h0;
  logic [32:0] exp_q[$];
  int          pop_log[$];
  logic [31:0] ref_mem [0:255] = '{default: 32'h0};
  logic [31:0] mac_mem [0:255] = '{default: 32'h0};

  sram_port_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .RSP_DEPTH(2)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wmask  (req_wmask),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_we     (rsp_we),
    .rsp_rdata  (rsp_rdata),
    .sram_csb   (sram_csb),
    .sram_web   (sram_web),
    .sram_wmask (sram_wmask),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout)
  );

  // Clock / reset-independent infrastructure
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Macro model: samples on the rising edge, writes or drives dout after the falling edge.
  logic          s_act = 1'b0;
  logic          s_we  = 1'b0;
  logic [3:0]    s_mask;
  logic [AW-1:0] s_addr;
  logic [31:0]   s_din;

  always @(posedge clock) begin
    s_act  <= !sram_csb;
    s_we   <= !sram_web;
    s_mask <= sram_wmask;
    s_addr <= sram_addr;
    s_din  <= sram_din;
  end

  always @(negedge clock) begin
    if (s_act) begin
      if (s_addr > AW'(255)) begin
        sram_dout <= 'x;
      end else if (s_we) begin
        for (int b = 0; b < 4; b++)
          if (s_mask[b]) mac_mem[s_addr[7:0]][8*b +: 8] <= s_din[8*b +: 8];
      end else begin
        sram_dout <= mac_mem[s_addr[7:0]];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: expectations pushed at request handshake, compared at response handshake.
  always @(negedge clock) begin
    logic [32:0] expv;
    if (reset_n) begin
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 64'(rsp_valid), 64'd0);
        end else begin
          expv = exp_q.pop_front();
          check("rsp_data", {31'b0, rsp_we, rsp_rdata}, {31'b0, expv});
        end
        last_rdata = rsp_rdata;
        pop_log.push_back(cyc);
        n_pop++;
      end
      if (req_valid && req_ready) begin
        if (req_we) begin
          for (int b = 0; b < 4; b++)
            if (req_wmask[b]) ref_mem[req_addr[7:0]][8*b +: 8] = req_wdata[8*b +: 8];
          exp_q.push_back({1'b1, 32'h0});
        end else begin
          exp_q.push_back({1'b0, ref_mem[req_addr[7:0]]});
        end
        n_acc++;
      end
    end
  end

  // Driver tasks
  task automatic send(input logic we, input logic [AW-1:0] a, input logic [31:0] d,
                      input logic [3:0] m, output int waits);
    logic got;
    got   = 1'b0;
    waits = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_wmask = m;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clock);
      got = req_ready;
      if (!got) waits++;
      @(posedge clock); #1;
    end
    check("accept_timeout", 64'(got), 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int w;
    int stall;
    int base_acc;
    int base_pop;
    int n;
    int k;
    int stale;
    logic fire;

    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wmask = '0;
    rsp_ready = 1'b1;
    reset_n   = 1'b0;

    // Reset state, with a request offered while reset is held
    repeat (2) @(posedge clock);
    #1 req_valid = 1'b1;
    #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_csb", 64'(sram_csb), 64'd1);
    req_valid = 1'b0;
    @(posedge clock); #1 reset_n = 1'b1;
    @(negedge clock);
    check("post_rst_ready", 64'(req_ready), 64'd1);
    check("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    @(posedge clock); #1;

    // Write then read back on the next edge, with latency and macro port checks
    req_valid = 1'b1; req_we = 1'b1; req_addr = AW'('h10);
    req_wdata = 32'hDEADBEEF; req_wmask = 4'hF;
    @(negedge clock);
    check("wr_ready", 64'(req_ready), 64'd1);
    check("wr_csb", 64'(sram_csb), 64'd0);
    check("wr_web", 64'(sram_web), 64'd0);
    check("wr_wmask", 64'(sram_wmask), 64'hF);
    check("wr_addr", 64'(sram_addr), 64'h10);
    check("wr_din", 64'(sram_din), 64'hDEADBEEF);
    @(posedge clock); #1;
    req_we = 1'b0; req_wdata = 32'h0;
    @(negedge clock);
    check("rd_ready", 64'(req_ready), 64'd1);
    check("rd_web", 64'(sram_web), 64'd1);
    check("rd_wmask", 64'(sram_wmask), 64'h0);
    check("lat_wr_c1", 64'(rsp_valid), 64'd0);
    @(posedge clock); #1 req_valid = 1'b0;
    @(negedge clock);
    check("lat_wr_c2", 64'(rsp_valid), 64'd1);
    check("lat_wr_we", 64'(rsp_we), 64'd1);
    @(posedge clock); #1;
    @(negedge clock);
    check("lat_rd_c2", 64'(rsp_valid), 64'd1);
    check("rd_data", 64'(rsp_rdata), 64'hDEADBEEF);
    @(posedge clock); #1;
    drain();

    // Byte mask merge, then an all-zero mask write that must change nothing
    send(1'b1, AW'('h20), 32'h11223344, 4'hF, w);
    send(1'b1, AW'('h20), 32'hAABBCCDD, 4'b0101, w);
    send(1'b0, AW'('h20), 32'h0, 4'h0, w);
    drain();
    check("mask_0101", 64'(last_rdata), 64'h11BB33DD);
    base_pop = n_pop;
    send(1'b1, AW'('h20), 32'hFFFFFFFF, 4'b0000, w);
    send(1'b0, AW'('h20), 32'h0, 4'h0, w);
    drain();
    check("mask_0000_data", 64'(last_rdata), 64'h11BB33DD);
    check("mask_0000_rsps", 64'(n_pop - base_pop), 64'd2);

    // Back-to-back: preload i*3, then 8 consecutive reads
    for (int i = 0; i < 8; i++) send(1'b1, AW'(i), 32'(i * 3), 4'hF, w);
    drain();
    pop_log.delete();
    stall = 0;
    for (int i = 0; i < 8; i++) begin
      send(1'b0, AW'(i), 32'h0, 4'h0, w);
      stall += w;
    end
    drain();
    check("b2b_stalls", 64'(stall), 64'd0);
    check("b2b_count", 64'(pop_log.size()), 64'd8);
    if (pop_log.size() == 8) check("b2b_span", 64'(pop_log[7] - pop_log[0]), 64'd7);
    check("b2b_last", 64'(last_rdata), 64'd21);

    // Back-pressure: responses stalled, continuous requests
    rsp_ready = 1'b0;
    base_acc  = n_acc;
    req_valid = 1'b1; req_we = 1'b0; req_addr = '0; req_wmask = 4'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      fire = req_ready;
      @(posedge clock); #1;
      if (fire) req_addr = req_addr + AW'(1);
    end
    @(negedge clock);
    check("bp_accepted", 64'(n_acc - base_acc), 64'd2);
    check("bp_ready_low", 64'(req_ready), 64'd0);
    @(posedge clock); #1 rsp_ready = 1'b1;
    @(negedge clock);
    check("bp_resume_valid", 64'(rsp_valid), 64'd1);
    check("bp_resume_ready", 64'(req_ready), 64'd1);
    @(posedge clock); #1 req_addr = req_addr + AW'(1);
    @(posedge clock); #1;
    drain();

    // Random mix with random response back-pressure
    base_acc = n_acc;
    base_pop = n_pop;
    n = 0;
    k = 0;
    req_valid = 1'b0;
    while (n < 20 && k < 400) begin
      rsp_ready = 1'($urandom_range(0, 1));
      if (!req_valid) begin
        req_valid = 1'b1;
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = AW'($urandom_range(0, 15));
        req_wdata = $urandom;
        req_wmask = 4'($urandom_range(0, 15));
      end
      @(negedge clock);
      fire = req_valid && req_ready;
      @(posedge clock); #1;
      if (fire) begin
        n++;
        req_valid = 1'b0;
      end
      k++;
    end
    check("rand_accepted", 64'(n), 64'd20);
    drain();
    check("rand_balance", 64'(n_pop - base_pop), 64'(n_acc - base_acc));

    // Reset with a read in flight: no stale response afterwards
    send(1'b0, AW'(3), 32'h0, 4'h0, w);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_csb", 64'(sram_csb), 64'd1);
    check("mid_rst_ready", 64'(req_ready), 64'd0);
    exp_q.delete();
    req_valid = 1'b0;
    @(posedge clock); #1 reset_n = 1'b1;
    @(negedge clock);
    check("mid_rst_release_ready", 64'(req_ready), 64'd1);
    stale = 0;
    repeat (5) begin
      if (rsp_valid) stale++;
      @(negedge clock);
    end
    check("mid_rst_stale", 64'(stale), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
